// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared SPI definitions: R/W encodings, frame length helper
//               and the frame state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam logic SPI_RW_WRITE = 1'b1;
    localparam logic SPI_RW_READ  = 1'b0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4
    } spi_state_t;

    // Frame length in bits: one R/W bit, then address, then data
    function automatic int spi_frame_len(input int a, input int d);
        return 1 + a + d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : 2-FF synchronizer followed by an edge-detect stage. The
//               level output is delayed so it lines up with rise/fall.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_dly;
    logic r_rise;
    logic r_fall;

    // Synchronize the pin and register one-cycle edge events
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_dly  <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_dly  <= r_sync;
            r_rise <= r_sync & ~r_dly;
            r_fall <= ~r_sync & r_dly;
        end
    end

    assign level = r_dly;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/spi_reg_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_responder
// Description : Oversampled SPI mode-0 slave owning a 2**A x D register
//               file, with a local read port and a write notification.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_responder
    import spi_pkg::*;
#(
    parameter int A = 8,
    parameter int D = 8
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic         SS,
    input  logic         SCLK,
    input  logic         MOSI,
    output logic         MISO,
    input  logic [A-1:0] RADDR,
    output logic [D-1:0] RDATA,
    output logic         WR_STB,
    output logic [A-1:0] WR_ADDR,
    output logic [D-1:0] WR_DATA,
    output logic         FRAME_ERR
);

    localparam int c_N     = spi_frame_len(A, D);
    localparam int c_CW    = $clog2(c_N + 1);
    localparam int c_DEPTH = 2 ** A;

    logic w_ss_lvl, w_ss_rise, w_ss_fall;
    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_unused_sclk_lvl;
    logic [2:0] r_mosi_pipe;
    logic w_mosi;

    spi_state_t r_state, w_next;
    logic [c_CW-1:0] r_bitcnt;
    logic            r_rw;
    logic [A-1:0]    r_addr;
    logic [D-1:0]    r_rx;
    logic [D-1:0]    r_tx;
    logic            r_miso;
    logic [D-1:0]    r_regs [c_DEPTH];
    logic [D-1:0]    r_rdata;
    logic            r_wr_stb;
    logic [A-1:0]    r_wr_addr;
    logic [D-1:0]    r_wr_data;
    logic            r_frame_err;
    logic [1:0]      r_flush;
    logic            r_armed;

    logic w_rise, w_fall, w_active;
    logic w_last_addr, w_last_data;
    logic w_start, w_abort, w_commit, w_load_tx, w_tx_shift, w_miso_next;
    logic [A-1:0] w_addr_shift;
    logic [D-1:0] w_rx_shift;

    spi_sync_edge #(.RESET_VAL(1'b1)) u_ss_sync (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .din   (SS),
        .level (w_ss_lvl),
        .rise  (w_ss_rise),
        .fall  (w_ss_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .din   (SCLK),
        .level (w_sclk_lvl),
        .rise  (w_sclk_rise),
        .fall  (w_sclk_fall)
    );

    assign w_unused_sclk_lvl = w_sclk_lvl;

    // MOSI needs only its level, delayed to line up with the SCLK events
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_mosi_pipe <= 3'b000;
        end else begin
            r_mosi_pipe <= {r_mosi_pipe[1:0], MOSI};
        end
    end
    assign w_mosi = r_mosi_pipe[2];

    // An SS rise in the same cycle discards any SCLK event
    assign w_rise       = w_sclk_rise & ~w_ss_rise;
    assign w_fall       = w_sclk_fall & ~w_ss_rise;
    assign w_active     = (r_state == CMD) || (r_state == ADDR) || (r_state == DATA);
    assign w_last_addr  = (r_bitcnt == c_CW'(A));
    assign w_last_data  = (r_bitcnt == c_CW'(c_N - 1));
    assign w_addr_shift = {w_mosi, r_addr[A-1:1]};
    assign w_rx_shift   = {w_mosi, r_rx[D-1:1]};

    // Arm only after the synchronizer has flushed and SS is seen high, so a
    // frame already in progress at reset release is never joined
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_flush <= 2'd0;
            r_armed <= 1'b0;
        end else if (r_flush != 2'd3) begin
            r_flush <= r_flush + 2'd1;
        end else if (w_ss_lvl) begin
            r_armed <= 1'b1;
        end
    end

    // Frame state register
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; SS rise takes priority over any SCLK event
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_ss_fall && r_armed) w_next = CMD;
            CMD: begin
                if (w_ss_rise)   w_next = IDLE;
                else if (w_rise) w_next = ADDR;
            end
            ADDR: begin
                if (w_ss_rise)                  w_next = IDLE;
                else if (w_rise && w_last_addr) w_next = DATA;
            end
            DATA: begin
                if (w_ss_rise)                  w_next = IDLE;
                else if (w_rise && w_last_data) w_next = DONE;
            end
            DONE: if (w_ss_rise) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Per-state control strobes and the next MISO value
    always_comb begin
        w_start     = 1'b0;
        w_abort     = 1'b0;
        w_commit    = 1'b0;
        w_load_tx   = 1'b0;
        w_tx_shift  = 1'b0;
        w_miso_next = 1'b0;
        case (r_state)
            IDLE: w_start = w_ss_fall & r_armed;
            CMD:  w_abort = w_ss_rise;
            ADDR: begin
                w_abort   = w_ss_rise;
                w_load_tx = w_rise & w_last_addr & (r_rw == SPI_RW_READ);
            end
            DATA: begin
                w_abort  = w_ss_rise;
                w_commit = w_rise & w_last_data & (r_rw == SPI_RW_WRITE);
                if (r_rw == SPI_RW_READ && !w_ss_rise) begin
                    if (w_fall) begin
                        w_miso_next = r_tx[0];
                        w_tx_shift  = 1'b1;
                    end else begin
                        w_miso_next = r_miso;
                    end
                end
            end
            default: ;
        endcase
    end

    // Bit counter and frame shift registers
    always_ff @(posedge CLOCK) begin
        if (RESET || w_start) begin
            r_bitcnt <= '0;
            r_rw     <= 1'b0;
            r_addr   <= '0;
            r_rx     <= '0;
            r_tx     <= '0;
        end else begin
            if (w_active && w_rise && r_bitcnt != c_CW'(c_N)) r_bitcnt <= r_bitcnt + 1'b1;
            if (r_state == CMD && w_rise)  r_rw   <= w_mosi;
            if (r_state == ADDR && w_rise) r_addr <= w_addr_shift;
            if (r_state == DATA && w_rise && r_rw == SPI_RW_WRITE) r_rx <= w_rx_shift;
            if (w_load_tx)       r_tx <= r_regs[w_addr_shift];
            else if (w_tx_shift) r_tx <= r_tx >> 1;
        end
    end

    // Register file: cleared on reset, written when a write frame completes
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int i = 0; i < c_DEPTH; i++) r_regs[i] <= '0;
        end else if (w_commit) begin
            r_regs[r_addr] <= w_rx_shift;
        end
    end

    // Registered outputs: local read, write notification, abort flag, MISO
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_rdata     <= '0;
            r_wr_stb    <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_frame_err <= 1'b0;
            r_miso      <= 1'b0;
        end else begin
            r_rdata     <= r_regs[RADDR];
            r_wr_stb    <= w_commit;
            r_frame_err <= w_abort;
            r_miso      <= w_miso_next;
            if (w_commit) begin
                r_wr_addr <= r_addr;
                r_wr_data <= w_rx_shift;
            end
        end
    end

    assign MISO      = r_miso;
    assign RDATA     = r_rdata;
    assign WR_STB    = r_wr_stb;
    assign WR_ADDR   = r_wr_addr;
    assign WR_DATA   = r_wr_data;
    assign FRAME_ERR = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_responder
// Description : Scoreboard bench for spi_reg_responder with a behavioural
//               register-file model and randomized SPI frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_responder;

    localparam int A    = 8;
    localparam int D    = 8;
    localparam int N    = 1 + A + D;
    localparam int HALF = 5;

    logic         CLOCK = 1'b0;
    logic         RESET;
    logic         SS;
    logic         SCLK;
    logic         MOSI;
    logic         MISO;
    logic [A-1:0] RADDR;
    logic [D-1:0] RDATA;
    logic         WR_STB;
    logic [A-1:0] WR_ADDR;
    logic [D-1:0] WR_DATA;
    logic         FRAME_ERR;

    always #5 CLOCK = ~CLOCK;

    spi_reg_responder #(.A(A), .D(D)) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .SS        (SS),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .RADDR     (RADDR),
        .RDATA     (RDATA),
        .WR_STB    (WR_STB),
        .WR_ADDR   (WR_ADDR),
        .WR_DATA   (WR_DATA),
        .FRAME_ERR (FRAME_ERR)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] model [256];

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] old;
    } wr_t;

    wr_t        wr_q[$];
    int         ferr_exp = 0;
    logic       miso_exp_q[$];
    logic       miso_obs_q[$];
    logic [7:0] rd_exp_q[$];
    logic [7:0] rd_obs_q[$];
    logic       pend_new = 1'b0;
    logic [7:0] pend_val = 8'h00;
    wr_t        mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents an output
    always @(negedge CLOCK) begin
        if (!RESET) begin
            if (pend_new) begin
                chk("collide_new", RDATA, pend_val);
                pend_new = 1'b0;
            end
            if (WR_STB) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", 1, 0);
                end else begin
                    mon_e = wr_q.pop_front();
                    chk("wr_addr", WR_ADDR, mon_e.addr);
                    chk("wr_data", WR_DATA, mon_e.data);
                    if (RADDR == mon_e.addr) begin
                        chk("collide_old", RDATA, mon_e.old);
                        pend_new = 1'b1;
                        pend_val = mon_e.data;
                    end
                end
            end
            if (FRAME_ERR) begin
                if (ferr_exp == 0) chk("ferr_unexpected", 1, 0);
                else begin
                    ferr_exp--;
                    checks++;
                end
            end
            while (miso_obs_q.size() > 0 && miso_exp_q.size() > 0)
                chk("miso", miso_obs_q.pop_front(), miso_exp_q.pop_front());
            while (rd_obs_q.size() > 0 && rd_exp_q.size() > 0)
                chk("rdata", rd_obs_q.pop_front(), rd_exp_q.pop_front());
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    // One SCLK period: drive MOSI while low, sample MISO just before the rise
    task automatic sclk_pulse(input logic mosi_bit, input logic exp_miso);
        MOSI = mosi_bit;
        wait_clk(HALF);
        miso_obs_q.push_back(MISO);
        miso_exp_q.push_back(exp_miso);
        SCLK = 1'b1;
        wait_clk(HALF);
        SCLK = 1'b0;
    endtask

    // Full or truncated frame; cut < N raises SS after cut rises
    task automatic spi_frame(input logic rw, input logic [7:0] addr, input logic [7:0] data,
                             input int cut, input int extra);
        logic [N-1:0] bits;
        logic [7:0]   mv;
        logic         e;
        int           nb;
        bits[0] = rw;
        for (int i = 0; i < A; i++) bits[1+i] = addr[i];
        for (int j = 0; j < D; j++) bits[1+A+j] = data[j];
        nb = (cut < N) ? cut : N;
        mv = model[addr];
        if (nb < N) ferr_exp++;
        else if (rw) begin
            wr_q.push_back('{addr: addr, data: data, old: model[addr]});
            model[addr] = data;
        end
        SS = 1'b0;
        wait_clk(6);
        for (int i = 0; i < nb; i++) begin
            e = (!rw && i > A) ? mv[i-1-A] : 1'b0;
            sclk_pulse(bits[i], e);
        end
        if (nb == N)
            for (int k = 0; k < extra; k++) sclk_pulse(1'($urandom_range(0, 1)), 1'b0);
        wait_clk(HALF);
        SS = 1'b1;
        wait_clk(12);
    endtask

    task automatic local_read(input logic [7:0] a);
        RADDR = a;
        rd_exp_q.push_back(model[a]);
        wait_clk(2);
        rd_obs_q.push_back(RDATA);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mv;
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        RESET = 1'b1; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0; RADDR = '0;
        wait_clk(5);
        chk("rst_miso", MISO, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_wr_stb", WR_STB, 0);
        chk("rst_wr_addr", WR_ADDR, 0);
        chk("rst_wr_data", WR_DATA, 0);
        chk("rst_frame_err", FRAME_ERR, 0);
        RESET = 1'b0;
        wait_clk(10);

        // Basic write then local read-back
        spi_frame(1'b1, 8'h3C, 8'hA5, N, 0);
        local_read(8'h3C);
        // Read frame returns 0xA5 LSB-first on MISO
        spi_frame(1'b0, 8'h3C, 8'h00, N, 0);
        // Abort after 5 data bits: no write, FRAME_ERR once
        spi_frame(1'b1, 8'h10, 8'h77, 1 + A + 5, 0);
        local_read(8'h10);
        // Extra SCLK pulses after a complete frame
        spi_frame(1'b1, 8'h44, 8'h3E, N, 3);
        spi_frame(1'b0, 8'h44, 8'h00, N, 3);
        // Local read colliding with the SPI write commit
        RADDR = 8'h20;
        wait_clk(2);
        spi_frame(1'b1, 8'h20, 8'hFF, N, 0);
        local_read(8'h20);

        // Randomized frames against the model
        for (int t = 0; t < 24; t++) begin
            logic       rw;
            logic [7:0] a, d;
            int         cut;
            rw  = 1'($urandom_range(0, 1));
            a   = 8'($urandom_range(0, 7));
            d   = 8'($urandom);
            cut = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, N - 1)) : N;
            spi_frame(rw, a, d, cut, int'($urandom_range(0, 2)));
            local_read(8'($urandom_range(0, 7)));
        end

        // Reset in the middle of a read frame with SS held low
        mv = model[8'h3C];
        RADDR = 8'h00;
        SS = 1'b0;
        wait_clk(6);
        sclk_pulse(1'b0, 1'b0);
        for (int i = 0; i < A; i++) sclk_pulse(1'(8'h3C >> i), 1'b0);
        sclk_pulse(1'b0, mv[0]);
        sclk_pulse(1'b0, mv[1]);
        wait_clk(2);
        RESET = 1'b1;
        wait_clk(3);
        RESET = 1'b0;
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        for (int k = 0; k < 8; k++) sclk_pulse(1'($urandom_range(0, 1)), 1'b0);
        wait_clk(HALF);
        SS = 1'b1;
        wait_clk(12);
        spi_frame(1'b1, 8'h01, 8'h5A, N, 0);
        local_read(8'h01);
        local_read(8'h3C);

        wait_clk(20);
        chk("wr_pending", wr_q.size(), 0);
        chk("ferr_pending", ferr_exp, 0);
        chk("miso_pending", miso_exp_q.size(), 0);
        chk("rd_pending", rd_exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
